mwtxpkt_scheduler: RTL and testbench

Round-robin packet scheduler that shares one TX buffer write port between NUM_CH AXI-Stream packet sources.
- For each granted packet it writes a 2-byte destination-port header (MSB first), then the payload. It marks the last byte with eop.
- Honours TX-buffer almost-full backpressure and guards against runaway packets.
- Sits between the DUT-side stream channels and the Ethernet TX buffer in the dutclk domain.

---
 rtl/mwtxpkt_pkg.sv | 26 ++
 rtl/mwtxpkt_scheduler_if.sv | 24 ++
 rtl/mwrr_arbiter.sv | 17 +
 rtl/mwtxpkt_scheduler.sv | 159 +++++++++++++++
 tb/tb_mwtxpkt_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mwtxpkt_pkg.sv
// rtl/mwtxpkt_pkg.sv - shared state encoding, header length and round-robin helper
package mwtxpkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_HI  = 3'd1,
    ST_HDR_LO  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam int HDR_BYTES = 2;

  // First requester at or after ptr, wrapping at n; returns ptr when nothing requests.
  function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [2:0] pick;
    pick = ptr;
    for (int k = 7; k >= 0; k--) begin
      if (k < n && req[3'((int'(ptr) + k) % n)]) begin
        pick = 3'((int'(ptr) + k) % n);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mwtxpkt_scheduler_if.sv
// rtl/mwtxpkt_scheduler_if.sv - stream sources and TX buffer write port bundle
interface mwtxpkt_scheduler_if #(
  parameter int NUM_CH    = 4,
  parameter int DATAWIDTH = 8
);
  logic [NUM_CH*DATAWIDTH-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]           s_axis_tvalid;
  logic [NUM_CH-1:0]           s_axis_tlast;
  logic [NUM_CH-1:0]           s_axis_tready;
  logic [DATAWIDTH-1:0]        txbuffer_data;
  logic                        txbuffer_datavld;
  logic                        txbuffer_eop;
  logic                        txbuffer_afull;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, txbuffer_afull,
    output s_axis_tready, txbuffer_data, txbuffer_datavld, txbuffer_eop
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, txbuffer_afull,
    input  s_axis_tready, txbuffer_data, txbuffer_datavld, txbuffer_eop
  );
endinterface

// File: rtl/mwrr_arbiter.sv
// rtl/mwrr_arbiter.sv - combinational rotating-priority arbiter
module mwrr_arbiter
  import mwtxpkt_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [2:0]        ptr_i,
  input  logic              en_i,
  output logic [2:0]        grant_o,
  output logic              valid_o
);

  assign grant_o = rr_next(8'(req_i), ptr_i, NUM_CH);
  assign valid_o = en_i & (|req_i);

endmodule

// File: rtl/mwtxpkt_scheduler.sv
// rtl/mwtxpkt_scheduler.sv - round-robin packet scheduler into one TX buffer write port
module mwtxpkt_scheduler
  import mwtxpkt_pkg::*;
#(
  parameter int                   NUM_CH      = 4,
  parameter int                   DATAWIDTH   = 8,
  parameter logic [NUM_CH*16-1:0] DSTPORTS    = {NUM_CH{16'd8}},
  parameter int                   MAX_PKT_LEN = 1024,
  parameter int                   CNTW        = 11
) (
  input  logic                dutclk,
  input  logic                reset,
  mwtxpkt_scheduler_if.slave  bus,
  output logic [2:0]          grant_ch,
  output logic                busy,
  output logic                overflow_err
);

  localparam int              HDR_W    = 8 * HDR_BYTES;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_PKT_LEN - 1);

  state_t               state_q, state_d;
  logic [2:0]           rr_q, rr_d;
  logic [2:0]           grant_q, grant_d;
  logic [CNTW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                 ovf_q, ovf_d;
  logic [DATAWIDTH-1:0] txd_q, txd_d;
  logic                 txv_q, txv_d;
  logic                 txe_q, txe_d;

  logic [NUM_CH-1:0]    sel_oh;
  logic [NUM_CH-1:0]    tready;
  logic                 cur_valid, cur_last;
  logic [DATAWIDTH-1:0] cur_data;
  logic [HDR_W-1:0]     cur_hdr;
  logic [2:0]           rr_after;
  logic [2:0]           arb_grant;
  logic                 arb_valid;

  mwrr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i   (bus.s_axis_tvalid),
    .ptr_i   (rr_q),
    .en_i    (state_q == ST_IDLE),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  always_comb begin
    cur_data = '0;
    cur_hdr  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q == 3'(i)) begin
        cur_data = bus.s_axis_tdata[i*DATAWIDTH +: DATAWIDTH];
        cur_hdr  = DSTPORTS[i*HDR_W +: HDR_W];
      end
    end
  end

  assign sel_oh    = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_q;
  assign cur_valid = |(bus.s_axis_tvalid & sel_oh);
  assign cur_last  = |(bus.s_axis_tlast & sel_oh);
  assign rr_after  = (grant_q == 3'(NUM_CH - 1)) ? 3'd0 : grant_q + 3'd1;
  // Saturate so a runaway source can never wrap the beat count.
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNTW'(1);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    txd_d   = '0;
    txv_d   = 1'b0;
    txe_d   = 1'b0;
    tready  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          cnt_d   = '0;
          state_d = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (!bus.txbuffer_afull) begin
          txv_d   = 1'b1;
          txd_d   = DATAWIDTH'(cur_hdr[HDR_W-1 -: 8]);
          state_d = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (!bus.txbuffer_afull) begin
          txv_d   = 1'b1;
          txd_d   = DATAWIDTH'(cur_hdr[7:0]);
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!bus.txbuffer_afull) begin
          tready = sel_oh;
        end
        if (cur_valid && !bus.txbuffer_afull) begin
          txv_d = 1'b1;
          txd_d = cur_data;
          cnt_d = cnt_inc;
          if (cur_last) begin
            txe_d   = 1'b1;
            rr_d    = rr_after;
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            txe_d   = 1'b1;
            ovf_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Swallow the rest of an oversize packet regardless of buffer state.
        tready = sel_oh;
        if (cur_valid && cur_last) begin
          rr_d    = rr_after;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge dutclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      txe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      txe_q   <= txe_d;
    end
  end

  assign bus.s_axis_tready    = tready;
  assign bus.txbuffer_data    = txd_q;
  assign bus.txbuffer_datavld = txv_q;
  assign bus.txbuffer_eop     = txe_q;
  assign grant_ch             = grant_q;
  assign busy                 = (state_q != ST_IDLE);
  assign overflow_err         = ovf_q;

endmodule

// File: tb/tb_mwtxpkt_scheduler.sv
// tb/tb_mwtxpkt_scheduler.sv - scoreboard bench for the round-robin TX packet scheduler
module tb_mwtxpkt_scheduler;

  localparam int          NCH  = 4;
  localparam int          MAXP = 6;
  localparam logic [63:0] DST  = {16'hC0DE, 16'h5A17, 16'h1388, 16'hABCD};

  typedef struct packed {logic [7:0] d; logic l;} beat_t;
  typedef struct packed {logic [7:0] d; logic eop; logic [2:0] ch; logic busy;} exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] grant_ch;
  logic       busy;
  logic       overflow_err;

  mwtxpkt_scheduler_if #(.NUM_CH(NCH), .DATAWIDTH(8)) bus ();

  mwtxpkt_scheduler #(
    .NUM_CH(NCH), .DATAWIDTH(8), .DSTPORTS(DST), .MAX_PKT_LEN(MAXP), .CNTW(4)
  ) dut (
    .dutclk       (clk),
    .reset        (rst),
    .bus          (bus),
    .grant_ch     (grant_ch),
    .busy         (busy),
    .overflow_err (overflow_err)
  );

  int         assert_cnt = 0;
  int         fail_cnt   = 0;
  int         cyc        = 0;
  beat_t      dq[NCH][$];
  int         mlen[NCH][$];
  logic [7:0] mdat[NCH][$];
  exp_t       exp_q[$];
  int         vld_cyc[$];
  int         mptr = 0;
  logic       movf = 1'b0;
  logic       mon_en = 1'b0;
  bit         shown[NCH];
  bit         inpkt[NCH];
  int         cnt[NCH];
  logic [NCH-1:0] last_acc = '0;
  logic       afull_at_edge = 1'b0;
  int         afull_pct = 0;
  int         gap_pct = 0;
  exp_t       mon_e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    assert_cnt++;
    if (act !== expv) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] hdr_of(input int c);
    logic [63:0] d;
    d = DST;
    return d[c*16 +: 16];
  endfunction

  // Scoreboard monitor: every issued byte must be the next predicted one.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (afull_at_edge) chk("no_issue_under_afull", 32'(bus.txbuffer_datavld), 0);
      if (bus.txbuffer_datavld) begin
        vld_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          assert_cnt++;
          fail_cnt++;
          $display("FAIL unexpected_byte: got %0h, expected no byte", bus.txbuffer_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tx_data",  32'(bus.txbuffer_data), 32'(mon_e.d));
          chk("tx_eop",   32'(bus.txbuffer_eop),  32'(mon_e.eop));
          chk("grant_ch", 32'(grant_ch),          32'(mon_e.ch));
          chk("busy",     32'(busy),              32'(mon_e.busy));
        end
      end else begin
        chk("eop_without_vld", 32'(bus.txbuffer_eop), 0);
      end
    end
  end

  // Stream sources: the first beat of a packet is held valid until taken, later beats may gap.
  initial begin
    logic [NCH-1:0]   tv, tl;
    logic [NCH*8-1:0] td;
    logic [3:0]       sel;
    beat_t            b;
    bus.s_axis_tvalid  = '0;
    bus.s_axis_tlast   = '0;
    bus.s_axis_tdata   = '0;
    bus.txbuffer_afull = 1'b0;
    for (int c = 0; c < NCH; c++) begin shown[c] = 0; inpkt[c] = 0; cnt[c] = 0; end
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (last_acc[c] && dq[c].size() > 0) begin
          b = dq[c].pop_front();
          shown[c] = 0;
          if (b.l) begin inpkt[c] = 0; cnt[c] = 0; end
          else begin inpkt[c] = 1; cnt[c]++; end
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (!shown[c] && dq[c].size() > 0)
          shown[c] = !inpkt[c] || ($urandom_range(99) >= gap_pct);
        tv[c] = shown[c];
        if (shown[c]) begin
          td[c*8 +: 8] = dq[c][0].d;
          tl[c]        = dq[c][0].l;
        end else begin
          td[c*8 +: 8] = 8'($urandom);
          tl[c]        = 1'b0;
        end
      end
      bus.s_axis_tvalid  = tv;
      bus.s_axis_tlast   = tl;
      bus.s_axis_tdata   = td;
      bus.txbuffer_afull = ($urandom_range(99) < afull_pct);
      #1;
      last_acc      = bus.s_axis_tvalid & bus.s_axis_tready;
      afull_at_edge = bus.txbuffer_afull;
      if (mon_en && !rst) begin
        sel = 4'b0001 << grant_ch;
        chk("tready_only_grant", 32'(bus.s_axis_tready & ~sel), 0);
        if (bus.txbuffer_afull)
          chk("tready_under_afull", 32'(bus.s_axis_tready[grant_ch[1:0]]),
              32'(busy && cnt[grant_ch[1:0]] >= MAXP));
      end
    end
  end

  task automatic add_pkt(input int ch, input int len, input logic [7:0] d0,
                         input logic [7:0] step, input bit rnd);
    logic [7:0] v;
    for (int i = 0; i < len; i++) begin
      v = rnd ? 8'($urandom) : 8'(d0 + 8'(i) * step);
      dq[ch].push_back('{d: v, l: (i == len - 1)});
      mdat[ch].push_back(v);
    end
    mlen[ch].push_back(len);
  endtask

  // Reference: round-robin over channels with pending packets, header then capped payload.
  task automatic run_model();
    int  c, len, n;
    bit  found;
    logic [15:0] h;
    logic [7:0]  v;
    forever begin
      found = 0;
      c = 0;
      for (int k = 0; k < NCH && !found; k++) begin
        if (mlen[(mptr + k) % NCH].size() > 0) begin c = (mptr + k) % NCH; found = 1; end
      end
      if (!found) break;
      len = mlen[c].pop_front();
      n   = (len > MAXP) ? MAXP : len;
      h   = hdr_of(c);
      exp_q.push_back('{d: h[15:8], eop: 1'b0, ch: 3'(c), busy: 1'b1});
      exp_q.push_back('{d: h[7:0],  eop: 1'b0, ch: 3'(c), busy: 1'b1});
      for (int i = 0; i < len; i++) begin
        v = mdat[c].pop_front();
        if (i < n)
          exp_q.push_back('{d: v, eop: (i == n - 1), ch: 3'(c), busy: !((i == n - 1) && len <= MAXP)});
      end
      if (len > MAXP) movf = 1'b1;
      mptr = (c + 1) % NCH;
    end
  endtask

  function automatic bit drv_idle();
    for (int c = 0; c < NCH; c++) if (dq[c].size() > 0 || shown[c]) return 0;
    return 1;
  endfunction

  task automatic wait_done(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      #2;
      done = (exp_q.size() == 0) && !busy && drv_idle();
    end
    if (!done) begin
      assert_cnt++;
      fail_cnt++;
      $display("FAIL %s_timeout: got %0d bytes outstanding, expected 0", name, exp_q.size());
    end
    chk({name, "_overflow_err"}, 32'(overflow_err), 32'(movf));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_datavld"}, 32'(bus.txbuffer_datavld), 0);
    chk({name, "_data"},    32'(bus.txbuffer_data),    0);
    chk({name, "_eop"},     32'(bus.txbuffer_eop),     0);
    chk({name, "_busy"},    32'(busy),                 0);
    chk({name, "_grant"},   32'(grant_ch),             0);
    chk({name, "_ovf"},     32'(overflow_err),         0);
    chk({name, "_tready"},  32'(bus.s_axis_tready),    0);
  endtask

  initial begin
    bit any;
    rst = 1'b1;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Three contending channels with back-to-back single-beat packets.
    foreach (shown[c]) if (c != 1) begin add_pkt(c, 1, 0, 0, 1); add_pkt(c, 1, 0, 0, 1); end
    run_model();
    wait_done("rr_three");

    add_pkt(1, 3, 8'hAA, 8'h11, 0);
    run_model();
    wait_done("single_ch1");

    vld_cyc.delete();
    add_pkt(0, 1, 8'h5C, 0, 0);
    add_pkt(1, 1, 8'hC5, 0, 0);
    run_model();
    wait_done("b2b");
    chk("b2b_bytes", 32'(vld_cyc.size()), 6);
    if (vld_cyc.size() == 6) begin
      chk("b2b_span", 32'(vld_cyc[5] - vld_cyc[0]), 6);
      chk("b2b_idle_gap", 32'(vld_cyc[3] - vld_cyc[2]), 2);
    end

    add_pkt(2, 7, 8'h20, 8'h01, 0);
    add_pkt(3, 2, 8'h70, 8'h01, 0);
    run_model();
    wait_done("overflow");

    afull_pct = 25;
    gap_pct   = 30;
    for (int r = 0; r < 25; r++) begin
      any = 0;
      for (int c = 0; c < NCH; c++) begin
        for (int p = $urandom_range(2); p > 0; p--) begin
          add_pkt(c, $urandom_range(9, 1), 0, 0, 1);
          any = 1;
        end
      end
      if (!any) add_pkt($urandom_range(NCH - 1), $urandom_range(9, 1), 0, 0, 1);
      run_model();
      wait_done("random");
    end

    // Reset in the middle of channel 0's second payload beat.
    afull_pct = 0;
    gap_pct   = 0;
    add_pkt(0, 5, 8'h40, 8'h01, 0);
    run_model();
    any = 0;
    for (int i = 0; i < 200 && !any; i++) begin
      @(negedge clk);
      #2;
      any = (exp_q.size() <= 4);
    end
    if (!any) begin
      assert_cnt++;
      fail_cnt++;
      $display("FAIL midreset_sync: got %0d bytes outstanding, expected 4", exp_q.size());
    end
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    for (int c = 0; c < NCH; c++) begin
      dq[c].delete(); mlen[c].delete(); mdat[c].delete();
      shown[c] = 0; inpkt[c] = 0; cnt[c] = 0;
    end
    last_acc = '0;
    mptr     = 0;
    movf     = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;
    add_pkt(0, 2, 8'h90, 8'h01, 0);
    add_pkt(2, 1, 8'hE1, 0, 0);
    run_model();
    wait_done("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
